imm_sel_ctrl: RTL and testbench
===============================

IMM_SEL_CTRL -- requirements
Module: imm_sel_ctrl

Interface
REQ-001 Parameter: ILLEGAL_ZERO, default 1, 1 = immediate fields forced to zero for illegal opcodes.
REQ-002 Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- inst_i  in  32  instruction word from fetch.
- inst_valid_i  in  1  inst_i valid.
- inst_ready_o  out  1  block accepts inst_i this cycle.
- flush_i  in  1  discard all buffered entries.
- out_ready_i  in  1  downstream (immediate mux stage) accepts output.
- out_valid_o  out  1  output entry valid.
- imm_sel_o  out  2  immediate mux select: 00 U/J, 01 I, 10 S/B.
- imm_data0_o  out  20  20-bit field for select 00.
- imm_data1_o  out  12  12-bit field for select 01.
- imm_data2_o  out  12  12-bit field for select 10.
- illegal_o  out  1  output entry carries an unrecognised opcode.

Function
REQ-003 Decode on inst_i[6:0]:
- LUI 0110111 / AUIPC 0010111 -> sel 00, data0 = inst[31:12].
- JAL 1101111 -> sel 00, data0 = {inst[31],inst[19:12],inst[20],inst[30:21]}.
- OP-IMM 0010011 / LOAD 0000011 / JALR 1100111 -> sel 01, data1 = inst[31:20].
- STORE 0100011 -> sel 10, data2 = {inst[31:25],inst[11:7]}.
- BRANCH 1100011 -> sel 10, data2 = {inst[31],inst[7],inst[30:25],inst[11:8]}.
- Any other opcode -> sel 00, illegal = 1; all data fields 0 when ILLEGAL_ZERO = 1, otherwise decoded as for LUI.
REQ-004 Non-selected data fields SHALL be 0 in every entry.
REQ-005 Decode is combinational on input; the decoded entry is stored, so output latency is exactly 1 cycle from accept when the buffer is empty.
REQ-006 Accept occurs when inst_valid_i and inst_ready_o are both 1 on a rising edge; output transfer occurs when out_valid_o and out_ready_i are both 1.
REQ-007 Two-entry skid buffer; FSM states EMPTY, ONE, FULL.
REQ-008 Transitions:
- EMPTY + accept -> ONE.
- ONE + accept without transfer -> FULL.
- ONE + transfer without accept -> EMPTY.
- ONE + accept and transfer -> ONE.
- FULL + transfer -> ONE.
REQ-009 inst_ready_o = 1 in EMPTY and ONE, 0 in FULL; it SHALL NOT depend combinationally on out_ready_i.
REQ-010 Outputs are driven from the oldest entry; order is strictly FIFO.
REQ-011 out_valid_o = 1 in ONE and FULL.
REQ-012 When out_valid_o = 1 and out_ready_i = 0, all output fields SHALL hold stable.
REQ-013 flush_i = 1 on a rising edge:
- next state is EMPTY;
- any accept in that cycle is discarded;
- flush has priority over accept and transfer.
REQ-014 inst_i is ignored when inst_valid_i = 0.

Reset
REQ-015 rst_n low asynchronously forces:
- state EMPTY;
- out_valid_o 0, inst_ready_o 0;
- imm_sel_o 00, all data fields 0, illegal_o 0.
REQ-016 inst_ready_o rises on the first rising edge after rst_n deasserts.
REQ-017 Reset asserted mid-transfer drops all entries; no partial entry is presented after reset.

Structure
REQ-018 Shared package holds:
- opcode constants (OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_OP_IMM, OPC_LOAD, OPC_STORE, OPC_BRANCH);
- IMM_SEL_20 = 00, IMM_SEL_I = 01, IMM_SEL_SB = 10;
- FSM state encoding.
REQ-019 One sub-module imm_field_dec: purely combinational decode of REQ-003, instantiated once ahead of the buffer.

Verification
REQ-020 Reset, then inst 0x00500093 (addi), out_ready_i 1 -> next cycle out_valid_o 1, sel 01, data1 0x005, illegal 0.
REQ-021 Store 0xFE112E23 -> sel 10, data2 0xFFC; branch 0xFE000EE3 -> sel 10, data2 0xFFE.
REQ-022 out_ready_i 0, feed three valid instructions back-to-back:
- inst_ready_o drops after the second accept;
- the third is held off;
- raising out_ready_i yields all three in order with no loss.
REQ-023 FULL state plus flush_i together with inst_valid_i -> next cycle out_valid_o 0, inst_ready_o 1, no stale output.
REQ-024 Opcode 0x7F -> illegal_o 1, sel 00, data0 0x00000 (ILLEGAL_ZERO = 1).
REQ-025 Assert rst_n low asynchronously while FULL -> outputs take reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/imm_sel_ctrl_pkg.sv
// imm_sel_ctrl_pkg
//   Shared definitions for the immediate-select control block: RV32 base
//   opcodes that carry an immediate, immediate mux select codes, the skid
//   buffer FSM encoding and the buffered entry layout.
package imm_sel_ctrl_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [1:0] IMM_SEL_20 = 2'b00;
  localparam logic [1:0] IMM_SEL_I  = 2'b01;
  localparam logic [1:0] IMM_SEL_SB = 2'b10;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_FULL  = 2'b10
  } state_t;

  typedef struct packed {
    logic [1:0]  sel;
    logic [19:0] data0;
    logic [11:0] data1;
    logic [11:0] data2;
    logic        illegal;
  } imm_entry_t;

  localparam imm_entry_t ENTRY_ZERO = '0;

endpackage

// File: rtl/imm_sel_ctrl_dec.sv
// imm_field_dec
//   Purely combinational immediate field extraction from a 32-bit instruction.
//   Only the field matching imm_sel carries data; the other two are zero.
// Ports:
//   inst     in  32  instruction word
//   imm_sel  out  2  00 U/J, 01 I, 10 S/B
//   data0    out 20  U or J immediate field
//   data1    out 12  I immediate field
//   data2    out 12  S or B immediate field
//   illegal  out  1  opcode not recognised
module imm_field_dec
  import imm_sel_ctrl_pkg::*;
#(
  parameter bit ILLEGAL_ZERO = 1'b1
) (
  input  logic [31:0] inst,
  output logic [1:0]  imm_sel,
  output logic [19:0] data0,
  output logic [11:0] data1,
  output logic [11:0] data2,
  output logic        illegal
);

  always_comb begin
    imm_sel = IMM_SEL_20;
    data0   = '0;
    data1   = '0;
    data2   = '0;
    illegal = 1'b0;
    case (inst[6:0])
      OPC_LUI, OPC_AUIPC: data0 = inst[31:12];
      OPC_JAL:            data0 = {inst[31], inst[19:12], inst[20], inst[30:21]};
      OPC_OP_IMM, OPC_LOAD, OPC_JALR: begin
        imm_sel = IMM_SEL_I;
        data1   = inst[31:20];
      end
      OPC_STORE: begin
        imm_sel = IMM_SEL_SB;
        data2   = {inst[31:25], inst[11:7]};
      end
      OPC_BRANCH: begin
        imm_sel = IMM_SEL_SB;
        data2   = {inst[31], inst[7], inst[30:25], inst[11:8]};
      end
      default: begin
        illegal = 1'b1;
        // Optionally expose the raw U-type field for debug of illegal words.
        if (!ILLEGAL_ZERO) data0 = inst[31:12];
      end
    endcase
  end

endmodule

// File: rtl/imm_sel_ctrl.sv
// imm_sel_ctrl
//   Decodes the immediate fields of incoming instructions and buffers the
//   decoded entries in a two-entry skid buffer ahead of the immediate mux.
//   inst_ready_o is a registered function of buffer occupancy only, so it
//   never depends combinationally on out_ready_i.
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   inst_i/inst_valid_i    instruction word and its valid
//   inst_ready_o           block accepts inst_i this cycle
//   flush_i                discard all buffered entries
//   out_ready_i            downstream accepts output
//   out_valid_o            output entry valid
//   imm_sel_o, imm_data*_o decoded immediate select and fields (oldest entry)
//   illegal_o              output entry carries an unrecognised opcode
module imm_sel_ctrl
  import imm_sel_ctrl_pkg::*;
#(
  parameter bit ILLEGAL_ZERO = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] inst_i,
  input  logic        inst_valid_i,
  output logic        inst_ready_o,
  input  logic        flush_i,
  input  logic        out_ready_i,
  output logic        out_valid_o,
  output logic [1:0]  imm_sel_o,
  output logic [19:0] imm_data0_o,
  output logic [11:0] imm_data1_o,
  output logic [11:0] imm_data2_o,
  output logic        illegal_o
);

  imm_entry_t dec_p0;
  imm_entry_t slot0_p1;   // oldest entry, drives the outputs
  imm_entry_t slot1_p1;   // second entry, only live in ST_FULL
  state_t     state_p1;
  logic       rdy_p1;
  logic       vld_p1;
  logic       acc;
  logic       xfer;

  // ---- stage p0: combinational decode of the incoming word ----
  imm_field_dec #(
    .ILLEGAL_ZERO(ILLEGAL_ZERO)
  ) u_dec (
    .inst    (inst_i),
    .imm_sel (dec_p0.sel),
    .data0   (dec_p0.data0),
    .data1   (dec_p0.data1),
    .data2   (dec_p0.data2),
    .illegal (dec_p0.illegal)
  );

  assign acc  = inst_valid_i & rdy_p1;
  assign xfer = vld_p1 & out_ready_i;

  // ---- stage p1: two-entry skid buffer ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_p1 <= ST_EMPTY;
      rdy_p1   <= 1'b0;
      vld_p1   <= 1'b0;
      slot0_p1 <= ENTRY_ZERO;
      slot1_p1 <= ENTRY_ZERO;
    end else if (flush_i) begin
      state_p1 <= ST_EMPTY;
      rdy_p1   <= 1'b1;
      vld_p1   <= 1'b0;
      slot0_p1 <= ENTRY_ZERO;
      slot1_p1 <= ENTRY_ZERO;
    end else begin
      case (state_p1)
        ST_EMPTY: begin
          rdy_p1 <= 1'b1;
          if (acc) begin
            slot0_p1 <= dec_p0;
            vld_p1   <= 1'b1;
            state_p1 <= ST_ONE;
          end
        end
        ST_ONE: begin
          case ({acc, xfer})
            2'b10: begin
              slot1_p1 <= dec_p0;
              rdy_p1   <= 1'b0;
              state_p1 <= ST_FULL;
            end
            2'b01: begin
              slot0_p1 <= ENTRY_ZERO;
              vld_p1   <= 1'b0;
              state_p1 <= ST_EMPTY;
            end
            2'b11: slot0_p1 <= dec_p0;
            default: ;
          endcase
        end
        ST_FULL: begin
          if (xfer) begin
            slot0_p1 <= slot1_p1;
            slot1_p1 <= ENTRY_ZERO;
            rdy_p1   <= 1'b1;
            state_p1 <= ST_ONE;
          end
        end
        default: begin
          state_p1 <= ST_EMPTY;
          rdy_p1   <= 1'b1;
          vld_p1   <= 1'b0;
          slot0_p1 <= ENTRY_ZERO;
          slot1_p1 <= ENTRY_ZERO;
        end
      endcase
    end
  end

  assign inst_ready_o = rdy_p1;
  assign out_valid_o  = vld_p1;
  assign imm_sel_o    = slot0_p1.sel;
  assign imm_data0_o  = slot0_p1.data0;
  assign imm_data1_o  = slot0_p1.data1;
  assign imm_data2_o  = slot0_p1.data2;
  assign illegal_o    = slot0_p1.illegal;

endmodule

// File: tb/tb_imm_sel_ctrl.sv
module tb_imm_sel_ctrl;

  typedef struct packed {
    logic [1:0]  sel;
    logic [19:0] d0;
    logic [11:0] d1;
    logic [11:0] d2;
    logic        ill;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] inst_i = '0;
  logic        inst_valid_i = 1'b0;
  logic        inst_ready_o;
  logic        flush_i = 1'b0;
  logic        out_ready_i = 1'b0;
  logic        out_valid_o;
  logic [1:0]  imm_sel_o;
  logic [19:0] imm_data0_o;
  logic [11:0] imm_data1_o;
  logic [11:0] imm_data2_o;
  logic        illegal_o;

  int   n_tests = 0;
  int   n_fail  = 0;
  ent_t q[$];
  logic ready_en = 1'b0;

  imm_sel_ctrl #(.ILLEGAL_ZERO(1'b1)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .inst_i       (inst_i),
    .inst_valid_i (inst_valid_i),
    .inst_ready_o (inst_ready_o),
    .flush_i      (flush_i),
    .out_ready_i  (out_ready_i),
    .out_valid_o  (out_valid_o),
    .imm_sel_o    (imm_sel_o),
    .imm_data0_o  (imm_data0_o),
    .imm_data1_o  (imm_data1_o),
    .imm_data2_o  (imm_data2_o),
    .illegal_o    (illegal_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Reference decode: immediates reassembled from the instruction format
  // definitions (offset bits of J/B formats, split S field).
  function automatic ent_t ref_dec(input logic [31:0] w);
    ent_t e;
    logic [20:0] joff;
    logic [12:0] boff;
    e = '0;
    joff = {w[31], w[19:12], w[20], w[30:21], 1'b0};
    boff = {w[31], w[7], w[30:25], w[11:8], 1'b0};
    case (w[6:0])
      7'h37, 7'h17: e.d0 = w[31:12];
      7'h6F:        e.d0 = joff[20:1];
      7'h13, 7'h03, 7'h67: begin e.sel = 2'd1; e.d1 = w[31:20]; end
      7'h23: begin e.sel = 2'd2; e.d2 = {w[31:25], w[11:7]}; end
      7'h63: begin e.sel = 2'd2; e.d2 = boff[12:1]; end
      default: e.ill = 1'b1;
    endcase
    return e;
  endfunction

  task automatic compare_all();
    check("ready", {31'd0, inst_ready_o}, {31'd0, (ready_en && q.size() < 2)});
    check("valid", {31'd0, out_valid_o}, {31'd0, (q.size() > 0)});
    if (q.size() > 0) begin
      check("sel",   {30'd0, imm_sel_o},   {30'd0, q[0].sel});
      check("data0", {12'd0, imm_data0_o}, {12'd0, q[0].d0});
      check("data1", {20'd0, imm_data1_o}, {20'd0, q[0].d1});
      check("data2", {20'd0, imm_data2_o}, {20'd0, q[0].d2});
      check("illegal", {31'd0, illegal_o}, {31'd0, q[0].ill});
    end
  endtask

  // One clock: check outputs on the falling edge, drive inputs, advance model.
  task automatic step(input logic v, input logic [31:0] ins, input logic ordy, input logic fl);
    logic acc, xfer;
    @(negedge clk);
    compare_all();
    inst_valid_i = v;
    inst_i       = ins;
    out_ready_i  = ordy;
    flush_i      = fl;
    acc  = v && ready_en && (q.size() < 2);
    xfer = (q.size() > 0) && ordy;
    if (fl) q.delete();
    else begin
      if (xfer) void'(q.pop_front());
      if (acc) q.push_back(ref_dec(ins));
    end
    @(posedge clk);
    ready_en = 1'b1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, {31'd0, out_valid_o}, 32'd0);
    check({tag, "_ready"}, {31'd0, inst_ready_o}, 32'd0);
    check({tag, "_sel"},   {30'd0, imm_sel_o}, 32'd0);
    check({tag, "_data"},  {imm_data0_o, imm_data1_o} | {20'd0, imm_data2_o}, 32'd0);
    check({tag, "_ill"},   {31'd0, illegal_o}, 32'd0);
  endtask

  logic [6:0] opcs [10] = '{7'h37, 7'h17, 7'h6F, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h7F, 7'h33};

  initial begin
    logic [31:0] w;
    // Power-on reset
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("por");
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
    #1 check("ready_before_edge", {31'd0, inst_ready_o}, 32'd0);
    @(posedge clk);
    ready_en = 1'b1;
    #1 check("ready_after_edge", {31'd0, inst_ready_o}, 32'd1);

    // addi x1, x0, 5
    step(1'b1, 32'h0050_0093, 1'b1, 1'b0);
    #1;
    check("addi_valid", {31'd0, out_valid_o}, 32'd1);
    check("addi_sel",   {30'd0, imm_sel_o}, 32'd1);
    check("addi_data1", {20'd0, imm_data1_o}, 32'h005);
    check("addi_ill",   {31'd0, illegal_o}, 32'd0);

    // store then branch
    step(1'b1, 32'hFE11_2E23, 1'b1, 1'b0);
    #1;
    check("store_sel",   {30'd0, imm_sel_o}, 32'd2);
    check("store_data2", {20'd0, imm_data2_o}, 32'hFFC);
    check("store_d0",    {12'd0, imm_data0_o}, 32'd0);
    step(1'b1, 32'hFE00_0EE3, 1'b1, 1'b0);
    #1;
    check("branch_sel",   {30'd0, imm_sel_o}, 32'd2);
    check("branch_data2", {20'd0, imm_data2_o}, 32'hFFE);

    // illegal opcode
    step(1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0);
    #1;
    check("illeg_ill",   {31'd0, illegal_o}, 32'd1);
    check("illeg_sel",   {30'd0, imm_sel_o}, 32'd0);
    check("illeg_data0", {12'd0, imm_data0_o}, 32'd0);
    step(1'b0, 32'h0, 1'b1, 1'b0);

    // back-pressure: three back-to-back, third held off
    step(1'b1, 32'h0010_0093, 1'b0, 1'b0);
    step(1'b1, 32'h1234_5037, 1'b0, 1'b0);
    #1 check("full_ready", {31'd0, inst_ready_o}, 32'd0);
    step(1'b1, 32'h0040_0113, 1'b0, 1'b0);
    step(1'b1, 32'h0040_0113, 1'b0, 1'b0);
    #1 check("full_hold_data1", {20'd0, imm_data1_o}, 32'h001);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    #1 check("drain1_data0", {12'd0, imm_data0_o}, 32'h12345);
    step(1'b1, 32'h0040_0113, 1'b1, 1'b0);
    #1 check("drain2_data1", {20'd0, imm_data1_o}, 32'h004);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0);

    // flush while FULL with a new valid instruction
    step(1'b1, 32'h0010_0093, 1'b0, 1'b0);
    step(1'b1, 32'h0020_0093, 1'b0, 1'b0);
    step(1'b1, 32'h0030_0093, 1'b1, 1'b1);
    #1;
    check("flush_valid", {31'd0, out_valid_o}, 32'd0);
    check("flush_ready", {31'd0, inst_ready_o}, 32'd1);
    step(1'b0, 32'h0, 1'b1, 1'b0);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      w = $urandom;
      w[6:0] = opcs[$urandom_range(0, 9)];
      step(($urandom_range(0, 3) != 0), w, ($urandom_range(0, 2) != 0),
           ($urandom_range(0, 15) == 0));
    end

    // asynchronous reset while FULL
    step(1'b1, 32'h0010_0093, 1'b0, 1'b0);
    step(1'b1, 32'h0020_0093, 1'b0, 1'b0);
    step(1'b1, 32'h0020_0093, 1'b0, 1'b0);
    @(negedge clk);
    inst_valid_i = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("async");
    q.delete();
    ready_en = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b1;
    #1 check("rel_ready_before_edge", {31'd0, inst_ready_o}, 32'd0);
    check("rel_valid", {31'd0, out_valid_o}, 32'd0);
    @(posedge clk);
    ready_en = 1'b1;
    step(1'b1, 32'hFE11_2E23, 1'b1, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
